// File: rtl/pipe_share_pkg.sv
// pipe_share_pkg
//   Shared definitions for the pipe_share_sched block: default sizing,
//   the requester-ID width helper, the flush FSM encoding and the
//   default-configuration layout of one pipeline stage.
package pipe_share_pkg;

  localparam int NREQ_DEF = 4;
  localparam int W_DEF    = 8;

  // Number of bits needed to name one of n requesters (at least 1).
  function automatic int id_width(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

  localparam int IDW_DEF = id_width(NREQ_DEF);

  typedef enum logic [1:0] {
    RUN,
    DRAIN,
    CLEAR
  } state_t;

  // One pipeline stage at the default sizing. The top declares the same
  // layout locally with its own parameter widths.
  typedef struct packed {
    logic               valid;
    logic [IDW_DEF-1:0] id;
    logic [W_DEF-1:0]   data;
    logic [W_DEF-1:0]   scale;
  } stage_t;

endpackage

// File: rtl/pipe_share_sched_rr_arbiter.sv
// rr_arbiter
//   Round-robin arbiter. The search starts at the pointer and moves upward
//   with wrap; after a grant to i the pointer moves to (i+1) mod NREQ.
// Ports:
//   clk, rst   clock, synchronous active-high reset (pointer -> 0)
//   en         grant enable; when low no grant is issued
//   req        per-requester request
//   grant      one-hot grant (combinational)
//   grant_id   index of the granted requester (valid when |grant)
module rr_arbiter #(
  parameter int NREQ = 4,
  parameter int IDW  = 2
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            en,
  input  logic [NREQ-1:0] req,
  output logic [NREQ-1:0] grant,
  output logic [IDW-1:0]  grant_id
);

  localparam int DW = 2 * NREQ;

  logic [IDW-1:0] ptr_reg;
  logic [IDW-1:0] ptr_next;
  logic [31:0]    ptr_ext;
  logic [DW-1:0]  window;
  logic [DW-1:0]  masked;
  logic [DW-1:0]  lowest;

  assign ptr_ext = 32'(ptr_reg);

  // Requests are laid out twice end to end; the window selects the NREQ
  // positions starting at the pointer, so the lowest set bit in the window
  // is the first requester at or after the pointer, wrapping around.
  for (genvar gi = 0; gi < DW; gi++) begin : g_win
    assign window[gi] = (32'(gi) >= ptr_ext) && (32'(gi) < ptr_ext + 32'(NREQ));
  end

  assign masked = {req, req} & window & {DW{en}};
  assign lowest = masked & (-masked);
  assign grant  = lowest[NREQ-1:0] | lowest[DW-1:NREQ];

  always_comb begin
    grant_id = '0;
    for (int k = 0; k < NREQ; k++) begin
      if (grant[k]) grant_id = IDW'(k);
    end
  end

  always_comb begin
    ptr_next = ptr_reg;
    if (|grant) ptr_next = (grant_id == IDW'(NREQ - 1)) ? '0 : grant_id + IDW'(1);
  end

  always_ff @(posedge clk) begin
    if (rst) ptr_reg <= '0;
    else     ptr_reg <= ptr_next;
  end

endmodule

// File: rtl/pipe_share_sched.sv
// pipe_share_sched
//   Shares one 3-stage datapath among NREQ requesters:
//     stage 1: sum = a + b, scale = issue count of that requester (+1)
//     stage 2: prod = sum[lo half] * sum[hi half]
//     stage 3: rsp_data = prod * scale (mod 2^W)
//   Round-robin arbitration on the request side, valid/ready response port
//   carrying the requester ID, and a flush FSM that drains the pipe and
//   clears the per-requester sequence counters.
// Ports:
//   clk, rst               clock, synchronous active-high reset
//   req_valid/req_ready    per-requester handshake (req_ready one-hot)
//   req_a, req_b           packed operands, requester i at [i*W +: W]
//   rsp_valid/rsp_ready    response handshake
//   rsp_id, rsp_data       requester and result of the current response
//   flush                  level request to drain and clear (rising edge acts)
//   flush_done             one-cycle pulse when the flush completes
//   busy                   any pipe stage holds valid data
module pipe_share_sched
  import pipe_share_pkg::*;
#(
  parameter int NREQ = NREQ_DEF,
  parameter int W    = W_DEF,
  parameter int IDW  = id_width(NREQ)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [NREQ-1:0] req_valid,
  input  logic [NREQ*W-1:0] req_a,
  input  logic [NREQ*W-1:0] req_b,
  output logic [NREQ-1:0] req_ready,
  output logic            rsp_valid,
  output logic [IDW-1:0]  rsp_id,
  output logic [W-1:0]    rsp_data,
  input  logic            rsp_ready,
  input  logic            flush,
  output logic            flush_done,
  output logic            busy
);

  localparam int HW = W / 2;

  typedef struct packed {
    logic           valid;
    logic [IDW-1:0] id;
    logic [W-1:0]   data;
    logic [W-1:0]   scale;
  } pstage_t;

  pstage_t        s1_reg;
  pstage_t        s2_reg;
  logic           rsp_valid_reg;
  logic [IDW-1:0] rsp_id_reg;
  logic [W-1:0]   rsp_data_reg;

  state_t         state_reg;
  logic           flush_q;
  logic           flush_done_reg;

  logic [W-1:0]   seq_reg [NREQ];

  logic            stall;
  logic            flush_rise;
  logic            grant_en;
  logic            pipe_empty;
  logic [NREQ-1:0] grant;
  logic [IDW-1:0]  grant_id;
  logic [W-1:0]    sel_a;
  logic [W-1:0]    sel_b;
  logic [W-1:0]    sel_scale;
  logic [HW-1:0]   s1_lo;
  logic [HW-1:0]   s1_hi;
  logic [W-1:0]    prod_next;

  assign stall      = rsp_valid_reg & ~rsp_ready;
  assign flush_rise = flush & ~flush_q;
  // The cycle that starts a flush already refuses new work.
  assign grant_en   = ~rst & (state_reg == RUN) & ~flush_rise & ~stall;
  assign pipe_empty = ~s1_reg.valid & ~s2_reg.valid & ~rsp_valid_reg;

  rr_arbiter #(
    .NREQ (NREQ),
    .IDW  (IDW)
  ) u_arb (
    .clk      (clk),
    .rst      (rst),
    .en       (grant_en),
    .req      (req_valid),
    .grant    (grant),
    .grant_id (grant_id)
  );

  // Operand and scale selection for the granted requester.
  always_comb begin
    sel_a     = '0;
    sel_b     = '0;
    sel_scale = '0;
    for (int k = 0; k < NREQ; k++) begin
      if (grant[k]) begin
        sel_a     = req_a[k*W +: W];
        sel_b     = req_b[k*W +: W];
        sel_scale = seq_reg[k] + W'(1);
      end
    end
  end

  // Halves of the sum multiply into exactly W bits, so no overflow here.
  assign s1_lo     = s1_reg.data[HW-1:0];
  assign s1_hi     = s1_reg.data[W-1:HW];
  assign prod_next = W'(s1_lo) * W'(s1_hi);

  // Sequence counters wrap naturally at 2^W.
  always_ff @(posedge clk) begin
    for (int k = 0; k < NREQ; k++) begin
      if (rst || state_reg == CLEAR) seq_reg[k] <= '0;
      else if (grant[k])             seq_reg[k] <= seq_reg[k] + W'(1);
    end
  end

  // Datapath: a stall freezes all three stages together.
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_reg        <= '0;
      s2_reg        <= '0;
      rsp_valid_reg <= 1'b0;
      rsp_id_reg    <= '0;
      rsp_data_reg  <= '0;
    end else if (!stall) begin
      s1_reg.valid <= |grant;
      if (|grant) begin
        s1_reg.id    <= grant_id;
        s1_reg.data  <= sel_a + sel_b;
        s1_reg.scale <= sel_scale;
      end
      s2_reg.valid <= s1_reg.valid;
      if (s1_reg.valid) begin
        s2_reg.id    <= s1_reg.id;
        s2_reg.data  <= prod_next;
        s2_reg.scale <= s1_reg.scale;
      end
      rsp_valid_reg <= s2_reg.valid;
      if (s2_reg.valid) begin
        rsp_id_reg   <= s2_reg.id;
        rsp_data_reg <= s2_reg.data * s2_reg.scale;
      end
    end
  end

  // Flush FSM. flush_done is raised on entry to CLEAR so it is high for
  // exactly the CLEAR cycle. Only a rising edge of flush starts a flush,
  // so a level still held after CLEAR does not restart it.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg      <= RUN;
      flush_q        <= 1'b0;
      flush_done_reg <= 1'b0;
    end else begin
      flush_q        <= flush;
      flush_done_reg <= 1'b0;
      case (state_reg)
        RUN: begin
          if (flush_rise) state_reg <= DRAIN;
        end
        DRAIN: begin
          if (pipe_empty) begin
            state_reg      <= CLEAR;
            flush_done_reg <= 1'b1;
          end
        end
        CLEAR: begin
          state_reg <= RUN;
        end
        default: begin
          state_reg <= RUN;
        end
      endcase
    end
  end

  assign req_ready  = grant;
  assign rsp_valid  = rsp_valid_reg;
  assign rsp_id     = rsp_id_reg;
  assign rsp_data   = rsp_data_reg;
  assign flush_done = flush_done_reg;
  assign busy       = s1_reg.valid | s2_reg.valid | rsp_valid_reg;

endmodule

// File: tb/tb_pipe_share_sched.sv
// tb_pipe_share_sched
//   Table-driven bench for pipe_share_sched (NREQ=4, W=8). Each table row is
//   one clock: inputs are driven at the falling edge and the outputs seen in
//   that same cycle are compared with hand-computed values. The sequence
//   counter wrap is a hand-written loop.
module tb_pipe_share_sched;

  logic        clk;
  logic        rst;
  logic [3:0]  req_valid;
  logic [31:0] req_a;
  logic [31:0] req_b;
  logic [3:0]  req_ready;
  logic        rsp_valid;
  logic [1:0]  rsp_id;
  logic [7:0]  rsp_data;
  logic        rsp_ready;
  logic        flush;
  logic        flush_done;
  logic        busy;

  int tests;
  int fails;

  pipe_share_sched #(
    .NREQ (4),
    .W    (8),
    .IDW  (2)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_a      (req_a),
    .req_b      (req_b),
    .req_ready  (req_ready),
    .rsp_valid  (rsp_valid),
    .rsp_id     (rsp_id),
    .rsp_data   (rsp_data),
    .rsp_ready  (rsp_ready),
    .flush      (flush),
    .flush_done (flush_done),
    .busy       (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        rst;
    logic [3:0]  rv;
    logic [31:0] a;
    logic [31:0] b;
    logic        rr;
    logic        fl;
    logic [3:0]  e_rdy;
    logic        e_v;
    logic [1:0]  e_id;
    logic [7:0]  e_d;
    logic        e_fd;
    logic        e_busy;
  } vec_t;

  vec_t tbl[$];

  // Every lane: a=0x12, b=0x21 -> sum 0x33 -> product 9.
  localparam logic [31:0] A9 = 32'h1212_1212;
  localparam logic [31:0] B9 = 32'h2121_2121;
  // Lane i: a=0x11*(i+1), b=0 -> products 1, 4, 9, 16.
  localparam logic [31:0] AR = 32'h4433_2211;
  localparam logic [31:0] BR = 32'h0000_0000;

  function automatic vec_t mk(input logic r, input logic [3:0] rv,
                              input logic [31:0] a, input logic [31:0] b,
                              input logic rr, input logic fl,
                              input logic [3:0] e_rdy, input logic e_v,
                              input logic [1:0] e_id, input logic [7:0] e_d,
                              input logic e_fd, input logic e_busy);
    vec_t v;
    v.rst = r; v.rv = rv; v.a = a; v.b = b; v.rr = rr; v.fl = fl;
    v.e_rdy = e_rdy; v.e_v = e_v; v.e_id = e_id; v.e_d = e_d;
    v.e_fd = e_fd; v.e_busy = e_busy;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic run_vec(input vec_t v, input int idx);
    @(negedge clk);
    rst       = v.rst;
    req_valid = v.rv;
    req_a     = v.a;
    req_b     = v.b;
    rsp_ready = v.rr;
    flush     = v.fl;
    #1;
    check($sformatf("row%0d.req_ready", idx), 32'(req_ready), 32'(v.e_rdy));
    check($sformatf("row%0d.rsp_valid", idx), 32'(rsp_valid), 32'(v.e_v));
    if (v.e_v) begin
      check($sformatf("row%0d.rsp_id", idx), 32'(rsp_id), 32'(v.e_id));
      check($sformatf("row%0d.rsp_data", idx), 32'(rsp_data), 32'(v.e_d));
    end
    check($sformatf("row%0d.flush_done", idx), 32'(flush_done), 32'(v.e_fd));
    check($sformatf("row%0d.busy", idx), 32'(busy), 32'(v.e_busy));
    $display("[TB] row %0d rst=%0b rv=%b rr=%0b fl=%0b -> rdy=%b v=%0b id=%0d d=0x%02h fd=%0b busy=%0b",
             idx, v.rst, v.rv, v.rr, v.fl, req_ready, rsp_valid, rsp_id, rsp_data, flush_done, busy);
  endtask

  task automatic build_table();
    // Single op on req0, then a repeat (scale 2).
    tbl.push_back(mk(0, 4'b0001, A9, B9, 1, 0, 4'b0001, 0, 0, 8'h00, 0, 0));
    tbl.push_back(mk(0, 4'b0000, A9, B9, 1, 0, 4'b0000, 0, 0, 8'h00, 0, 1));
    tbl.push_back(mk(0, 4'b0000, A9, B9, 1, 0, 4'b0000, 0, 0, 8'h00, 0, 1));
    tbl.push_back(mk(0, 4'b0001, A9, B9, 1, 0, 4'b0001, 1, 0, 8'h09, 0, 1));
    tbl.push_back(mk(0, 4'b0000, A9, B9, 1, 0, 4'b0000, 0, 0, 8'h00, 0, 1));
    tbl.push_back(mk(0, 4'b0000, A9, B9, 1, 0, 4'b0000, 0, 0, 8'h00, 0, 1));
    tbl.push_back(mk(0, 4'b0000, A9, B9, 1, 0, 4'b0000, 1, 0, 8'h12, 0, 1));
    tbl.push_back(mk(0, 4'b0000, A9, B9, 1, 0, 4'b0000, 0, 0, 8'h00, 0, 0));
    // Reset, then all four requesters held high: grants 0,1,2,3,0,1.
    tbl.push_back(mk(1, 4'b0000, AR, BR, 1, 0, 4'b0000, 0, 0, 8'h00, 0, 0));
    tbl.push_back(mk(0, 4'b1111, AR, BR, 1, 0, 4'b0001, 0, 0, 8'h00, 0, 0));
    tbl.push_back(mk(0, 4'b1111, AR, BR, 1, 0, 4'b0010, 0, 0, 8'h00, 0, 1));
    tbl.push_back(mk(0, 4'b1111, AR, BR, 1, 0, 4'b0100, 0, 0, 8'h00, 0, 1));
    tbl.push_back(mk(0, 4'b1111, AR, BR, 1, 0, 4'b1000, 1, 0, 8'h01, 0, 1));
    tbl.push_back(mk(0, 4'b1111, AR, BR, 1, 0, 4'b0001, 1, 1, 8'h04, 0, 1));
    tbl.push_back(mk(0, 4'b1111, AR, BR, 1, 0, 4'b0010, 1, 2, 8'h09, 0, 1));
    tbl.push_back(mk(0, 4'b0000, AR, BR, 1, 0, 4'b0000, 1, 3, 8'h10, 0, 1));
    tbl.push_back(mk(0, 4'b0000, AR, BR, 1, 0, 4'b0000, 1, 0, 8'h02, 0, 1));
    tbl.push_back(mk(0, 4'b0000, AR, BR, 1, 0, 4'b0000, 1, 1, 8'h08, 0, 1));
    tbl.push_back(mk(0, 4'b0000, AR, BR, 1, 0, 4'b0000, 0, 0, 8'h00, 0, 0));
    // Fill all three stages, reset mid-flight, then scale restarts at 1.
    tbl.push_back(mk(0, 4'b1111, AR, BR, 1, 0, 4'b0100, 0, 0, 8'h00, 0, 0));
    tbl.push_back(mk(0, 4'b1111, AR, BR, 1, 0, 4'b1000, 0, 0, 8'h00, 0, 1));
    tbl.push_back(mk(0, 4'b1111, AR, BR, 1, 0, 4'b0001, 0, 0, 8'h00, 0, 1));
    tbl.push_back(mk(1, 4'b0000, AR, BR, 1, 0, 4'b0000, 1, 2, 8'h12, 0, 1));
    tbl.push_back(mk(0, 4'b0100, AR, BR, 1, 0, 4'b0100, 0, 0, 8'h00, 0, 0));
    tbl.push_back(mk(0, 4'b0000, AR, BR, 1, 0, 4'b0000, 0, 0, 8'h00, 0, 1));
    tbl.push_back(mk(0, 4'b0000, AR, BR, 1, 0, 4'b0000, 0, 0, 8'h00, 0, 1));
    tbl.push_back(mk(0, 4'b0000, AR, BR, 1, 0, 4'b0000, 1, 2, 8'h09, 0, 1));
    tbl.push_back(mk(0, 4'b0000, AR, BR, 1, 0, 4'b0000, 0, 0, 8'h00, 0, 0));
    // Reset, then a req2 stream with rsp_ready low for two cycles.
    tbl.push_back(mk(1, 4'b0000, A9, B9, 1, 0, 4'b0000, 0, 0, 8'h00, 0, 0));
    tbl.push_back(mk(0, 4'b0100, A9, B9, 1, 0, 4'b0100, 0, 0, 8'h00, 0, 0));
    tbl.push_back(mk(0, 4'b0100, A9, B9, 1, 0, 4'b0100, 0, 0, 8'h00, 0, 1));
    tbl.push_back(mk(0, 4'b0100, A9, B9, 1, 0, 4'b0100, 0, 0, 8'h00, 0, 1));
    tbl.push_back(mk(0, 4'b0100, A9, B9, 0, 0, 4'b0000, 1, 2, 8'h09, 0, 1));
    tbl.push_back(mk(0, 4'b0100, A9, B9, 0, 0, 4'b0000, 1, 2, 8'h09, 0, 1));
    tbl.push_back(mk(0, 4'b0100, A9, B9, 1, 0, 4'b0100, 1, 2, 8'h09, 0, 1));
    tbl.push_back(mk(0, 4'b0100, A9, B9, 1, 0, 4'b0100, 1, 2, 8'h12, 0, 1));
    tbl.push_back(mk(0, 4'b0000, A9, B9, 1, 0, 4'b0000, 1, 2, 8'h1B, 0, 1));
    tbl.push_back(mk(0, 4'b0000, A9, B9, 1, 0, 4'b0000, 1, 2, 8'h24, 0, 1));
    tbl.push_back(mk(0, 4'b0000, A9, B9, 1, 0, 4'b0000, 1, 2, 8'h2D, 0, 1));
    tbl.push_back(mk(0, 4'b0000, A9, B9, 1, 0, 4'b0000, 0, 0, 8'h00, 0, 0));
    // Two req1 ops in flight, one-cycle flush: drain, pulse, seq cleared.
    tbl.push_back(mk(0, 4'b0010, A9, B9, 1, 0, 4'b0010, 0, 0, 8'h00, 0, 0));
    tbl.push_back(mk(0, 4'b0010, A9, B9, 1, 0, 4'b0010, 0, 0, 8'h00, 0, 1));
    tbl.push_back(mk(0, 4'b0010, A9, B9, 1, 1, 4'b0000, 0, 0, 8'h00, 0, 1));
    tbl.push_back(mk(0, 4'b0010, A9, B9, 1, 0, 4'b0000, 1, 1, 8'h09, 0, 1));
    tbl.push_back(mk(0, 4'b0010, A9, B9, 1, 0, 4'b0000, 1, 1, 8'h12, 0, 1));
    tbl.push_back(mk(0, 4'b0010, A9, B9, 1, 0, 4'b0000, 0, 0, 8'h00, 0, 0));
    tbl.push_back(mk(0, 4'b0010, A9, B9, 1, 0, 4'b0000, 0, 0, 8'h00, 1, 0));
    tbl.push_back(mk(0, 4'b0010, A9, B9, 1, 0, 4'b0010, 0, 0, 8'h00, 0, 0));
    tbl.push_back(mk(0, 4'b0000, A9, B9, 1, 0, 4'b0000, 0, 0, 8'h00, 0, 1));
    tbl.push_back(mk(0, 4'b0000, A9, B9, 1, 0, 4'b0000, 0, 0, 8'h00, 0, 1));
    tbl.push_back(mk(0, 4'b0000, A9, B9, 1, 0, 4'b0000, 1, 1, 8'h09, 0, 1));
    tbl.push_back(mk(0, 4'b0000, A9, B9, 1, 0, 4'b0000, 0, 0, 8'h00, 0, 0));
    // flush held high across CLEAR -> RUN must not start another flush.
    tbl.push_back(mk(0, 4'b0000, A9, B9, 1, 1, 4'b0000, 0, 0, 8'h00, 0, 0));
    tbl.push_back(mk(0, 4'b0000, A9, B9, 1, 1, 4'b0000, 0, 0, 8'h00, 0, 0));
    tbl.push_back(mk(0, 4'b0000, A9, B9, 1, 1, 4'b0000, 0, 0, 8'h00, 1, 0));
    tbl.push_back(mk(0, 4'b0001, A9, B9, 1, 1, 4'b0001, 0, 0, 8'h00, 0, 0));
    tbl.push_back(mk(0, 4'b0001, A9, B9, 1, 1, 4'b0001, 0, 0, 8'h00, 0, 1));
    tbl.push_back(mk(0, 4'b0000, A9, B9, 1, 0, 4'b0000, 0, 0, 8'h00, 0, 1));
    tbl.push_back(mk(0, 4'b0000, A9, B9, 1, 0, 4'b0000, 1, 0, 8'h09, 0, 1));
    tbl.push_back(mk(0, 4'b0000, A9, B9, 1, 0, 4'b0000, 1, 0, 8'h12, 0, 1));
    tbl.push_back(mk(0, 4'b0000, A9, B9, 1, 0, 4'b0000, 0, 0, 8'h00, 0, 0));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, tests=%0d failed=%0d", tests, fails);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] exp_d;
    tests     = 0;
    fails     = 0;
    rst       = 1'b1;
    req_valid = '0;
    req_a     = '0;
    req_b     = '0;
    rsp_ready = 1'b1;
    flush     = 1'b0;
    build_table();

    // Reset values.
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("reset.req_ready",  32'(req_ready),  32'h0);
    check("reset.rsp_valid",  32'(rsp_valid),  32'h0);
    check("reset.rsp_id",     32'(rsp_id),     32'h0);
    check("reset.rsp_data",   32'(rsp_data),   32'h0);
    check("reset.flush_done", 32'(flush_done), 32'h0);
    check("reset.busy",       32'(busy),       32'h0);
    $display("[TB] reset: rdy=%b v=%0b id=%0d d=0x%02h fd=%0b busy=%0b",
             req_ready, rsp_valid, rsp_id, rsp_data, flush_done, busy);

    foreach (tbl[i]) run_vec(tbl[i], i);

    // Sequence wrap: 256 ops on req3 with product 1, results 1..255 then 0.
    @(negedge clk);
    rst       = 1'b1;
    req_valid = '0;
    @(negedge clk);
    rst = 1'b0;
    for (int c = 0; c < 259; c++) begin
      @(negedge clk);
      req_valid = (c < 256) ? 4'b1000 : 4'b0000;
      req_a     = 32'h1111_1111;
      req_b     = 32'h0000_0000;
      rsp_ready = 1'b1;
      flush     = 1'b0;
      #1;
      if (c < 256) check($sformatf("wrap%0d.req_ready", c), 32'(req_ready), 32'h8);
      if (c >= 3) begin
        exp_d = 8'(c - 2);
        check($sformatf("wrap%0d.rsp_valid", c), 32'(rsp_valid), 32'h1);
        check($sformatf("wrap%0d.rsp_id", c),    32'(rsp_id),    32'h3);
        check($sformatf("wrap%0d.rsp_data", c),  32'(rsp_data),  32'(exp_d));
        $display("[TB] wrap op %0d: id=%0d d=0x%02h (want 0x%02h)", c - 3, rsp_id, rsp_data, exp_d);
      end
    end
    @(negedge clk);
    req_valid = '0;
    #1;
    check("wrap.end.rsp_valid", 32'(rsp_valid), 32'h0);
    check("wrap.end.busy",      32'(busy),       32'h0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
